sr_pq_sched: RTL and testbench

//  Multi-requester scheduler/front-end for one sr_pq shift-register priority queue.

---
 rtl/sr_pq_sched.sv | 166 ++++++++++++++++
 tb/tb_sr_pq_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pq_sched.sv
// Round-robin push arbiter and registered min-key drain stage in front of one sr_pq; optional stats via PQ_SCHED_STATS_EN.
// Latency: grant is combinational; a push accepted at edge t is earliest on out_valid after edge t+1.
// Backpressure: pq_full withholds all grants; out_valid & !out_ready holds out_kv and stops pops.
module sr_pq_sched #(
    parameter int NREQ = 4,
    parameter int KW   = 4,
    parameter int VW   = 4,
    parameter int CW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*(KW+VW)-1:0]    req_kv,
    output logic [NREQ-1:0]            req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [KW+VW-1:0]           out_kv,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       busy,
    output logic                       pq_push,
    output logic                       pq_pop,
    output logic [KW+VW-1:0]           pq_kvi,
    input  logic [KW+VW-1:0]           pq_kvo,
    input  logic                       pq_full,
    input  logic                       pq_empty
`ifdef PQ_SCHED_STATS_EN
    ,
    output logic [CW-1:0]              stat_push,
    output logic [CW-1:0]              stat_pop,
    output logic [CW-1:0]              stat_full_stall
`endif
);

    localparam int EW = KW + VW;
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || CW < 1) begin : g_param_chk
        $error("sr_pq_sched: NREQ must be >= 2 and CW >= 1");
    end

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          grant_any;
    logic          arb_en;
    int            idx;

    // A flush in RUN also blocks the grant so nothing lands in a PQ about to be drained.
    assign arb_en = !rst && (state == RUN) && !flush && !pq_full;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        idx       = 0;
        if (arb_en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!grant_any && req_valid[PW'(idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        pq_kvi    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (grant_idx == PW'(i))) begin
                req_ready[i] = 1'b1;
                pq_kvi       = req_kv[i*EW +: EW];
            end
        end
    end

    assign pq_push = grant_any;

    always_comb begin
        pq_pop = 1'b0;
        if (!rst) begin
            if (state == RUN) begin
                pq_pop = !pq_empty && (!out_valid || out_ready);
            end else begin
                pq_pop = !pq_empty;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = DRAIN;
            DRAIN:   if (pq_empty) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= PW'(NREQ - 1);
            out_valid  <= 1'b0;
            out_kv     <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= (state == DRAIN) && pq_empty;
            if (grant_any) begin
                rr_ptr <= grant_idx;
            end
            if (state == RUN) begin
                if (pq_pop) begin
                    out_kv    <= pq_kvo;
                    out_valid <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (flush) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign busy = !pq_empty || out_valid || (state == DRAIN);

`ifdef PQ_SCHED_STATS_EN
    localparam logic [CW-1:0] CMAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_push       <= '0;
            stat_pop        <= '0;
            stat_full_stall <= '0;
        end else begin
            if (pq_push && stat_push != CMAX) begin
                stat_push <= stat_push + CW'(1);
            end
            if (pq_pop && (state == RUN) && stat_pop != CMAX) begin
                stat_pop <= stat_pop + CW'(1);
            end
            if ((state == RUN) && (|req_valid) && pq_full && stat_full_stall != CMAX) begin
                stat_full_stall <= stat_full_stall + CW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sr_pq_sched.sv
// Bench for sr_pq_sched: behavioural 4-deep priority queue stub, vector table, corner sequences, random run vs. model.
module tb_sr_pq_sched;
    localparam int NREQ  = 4;
    localparam int KW    = 4;
    localparam int VW    = 4;
    localparam int CW    = 16;
    localparam int EW    = KW + VW;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*EW-1:0]   req_kv;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [EW-1:0]        out_kv;
    logic                 flush;
    logic                 flush_done;
    logic                 busy;
    logic                 pq_push;
    logic                 pq_pop;
    logic [EW-1:0]        pq_kvi;
    logic [EW-1:0]        pq_kvo;
    logic                 pq_full;
    logic                 pq_empty;
`ifdef PQ_SCHED_STATS_EN
    logic [CW-1:0]        stat_push;
    logic [CW-1:0]        stat_pop;
    logic [CW-1:0]        stat_full_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [EW-1:0] q[$];

    always #5 clk = ~clk;

    sr_pq_sched #(.NREQ(NREQ), .KW(KW), .VW(VW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_kv(req_kv), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_kv(out_kv),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .pq_push(pq_push), .pq_pop(pq_pop), .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty)
`ifdef PQ_SCHED_STATS_EN
        , .stat_push(stat_push), .stat_pop(stat_pop), .stat_full_stall(stat_full_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stable insert: an equal key goes behind existing ones.
    task automatic pq_insert(input logic [EW-1:0] kv);
        int j;
        j = 0;
        while (j < q.size() && q[j][EW-1:VW] <= kv[EW-1:VW]) j++;
        q.insert(j, kv);
    endtask

    // Advance one clock; the PQ stub reacts 1 time unit after the edge.
    task automatic step();
        logic s_push, s_pop, s_rst;
        logic [EW-1:0] s_kvi;
        s_push = pq_push; s_pop = pq_pop; s_kvi = pq_kvi; s_rst = rst;
        @(posedge clk);
        #1;
        if (s_rst) begin
            q.delete();
        end else begin
            if (s_pop && q.size() > 0) void'(q.pop_front());
            if (s_push) pq_insert(s_kvi);
        end
        pq_empty = (q.size() == 0);
        pq_full  = (q.size() == DEPTH);
        pq_kvo   = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic push_one(input int r, input logic [EW-1:0] kv, input string name);
        req_valid = NREQ'(1 << r);
        req_kv[r*EW +: EW] = kv;
        #2;
        chk(name, req_ready, 32'(1 << r));
        step();
        req_valid = '0;
    endtask

    typedef struct {
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] exp_rdy;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [EW-1:0] got[$];
        logic [EW-1:0] t3_exp[4];
        logic [EW-1:0] keys4[4];
        logic [CW-1:0] s0;
        int pops, dones;
        logic [NREQ-1:0] pend;
        logic [EW-1:0]   pkv[NREQ];
        int m_last, g;
        logic m_ov, ep;
        logic [EW-1:0] m_okv;

        rst = 1'b1; req_valid = '0; req_kv = '0; out_ready = 1'b0; flush = 1'b0;
        pq_kvo = '0; pq_full = 1'b0; pq_empty = 1'b1;

        // T1: reset with every requester asking
        req_valid = '1; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("t1_req_ready", req_ready, 0);
            chk("t1_pq_push", pq_push, 0);
            chk("t1_pq_pop", pq_pop, 0);
            step();
        end
        #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_flush_done", flush_done, 0);
        chk("t1_busy", busy, 0);
        rst = 1'b0;

        // T2: round-robin table
        vt[0]  = '{4'b1111, 4'b0001}; vt[1]  = '{4'b1111, 4'b0010};
        vt[2]  = '{4'b1111, 4'b0100}; vt[3]  = '{4'b1111, 4'b1000};
        vt[4]  = '{4'b1111, 4'b0001}; vt[5]  = '{4'b0101, 4'b0100};
        vt[6]  = '{4'b0101, 4'b0001}; vt[7]  = '{4'b0101, 4'b0100};
        vt[8]  = '{4'b0000, 4'b0000}; vt[9]  = '{4'b0010, 4'b0010};
        vt[10] = '{4'b1001, 4'b1000}; vt[11] = '{4'b1001, 4'b0001};
        for (int i = 0; i < NREQ; i++) req_kv[i*EW +: EW] = EW'(8'h11 * (i + 1));
        out_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            req_valid = vt[v].rv;
            #2;
            chk("t2_req_ready", req_ready, vt[v].exp_rdy);
            chk("t2_pq_push", pq_push, (vt[v].exp_rdy != 0));
            for (int i = 0; i < NREQ; i++)
                if (vt[v].exp_rdy[i]) chk("t2_pq_kvi", pq_kvi, 8'h11 * (i + 1));
            step();
        end
        req_valid = '0;

        // T3: priority order with one-entry lookahead, plus latency
        do_reset();
        keys4[0] = 8'h44; keys4[1] = 8'h11; keys4[2] = 8'h55; keys4[3] = 8'h33;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            req_kv[0 +: EW] = keys4[i];
            #2;
            chk("t3_req_ready", req_ready, 4'b0001);
            if (i == 1) chk("t3_lat_early", out_valid, 0);
            if (i == 2) chk("t3_lat_valid", out_valid, 1);
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (out_valid) got.push_back(out_kv);
            step();
        end
        t3_exp[0] = 8'h44; t3_exp[1] = 8'h11; t3_exp[2] = 8'h33; t3_exp[3] = 8'h55;
        chk("t3_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t3_order", (i < got.size()) ? got[i] : 8'hxx, t3_exp[i]);

        // T4: full PQ stalls all grants; one consumer accept frees one slot
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(1, EW'(8'h20 + i), "t4_fill");
        req_valid = 4'b0010;
        s0 = '0;
        for (int c = 0; c < 3; c++) begin
            #2;
`ifdef PQ_SCHED_STATS_EN
            if (c == 0) s0 = stat_full_stall;
`endif
            chk("t4_stall_ready", req_ready, 0);
            chk("t4_stall_push", pq_push, 0);
            chk("t4_stall_pop", pq_pop, 0);
            step();
        end
`ifdef PQ_SCHED_STATS_EN
        chk("t4_stat_full_stall", stat_full_stall, s0 + 3);
`endif
        out_ready = 1'b1;
        #2;
        chk("t4_accept_pop", pq_pop, 1);
        chk("t4_accept_ready", req_ready, 0);
        step();
        out_ready = 1'b0;
        #2;
        chk("t4_regrant", req_ready, 4'b0010);
        step();
        req_valid = '0;

        // T5: flush drains the PQ, single flush_done, grants resume
        do_reset();
        push_one(2, 8'h77, "t5_fill"); push_one(2, 8'h22, "t5_fill");
        push_one(2, 8'h99, "t5_fill"); push_one(2, 8'h11, "t5_fill");
        flush = 1'b1; req_valid = 4'b0100;
        #2;
        chk("t5_flush_grant", req_ready, 0);
        chk("t5_flush_push", pq_push, 0);
        step();
        req_valid = '0;
        pops = 0; dones = 0;
        for (int c = 0; c < 10; c++) begin
            flush = (c == 0);
            #2;
            if (c == 0) begin
                chk("t5_out_cleared", out_valid, 0);
                chk("t5_busy_drain", busy, 1);
            end
            pops  += int'(pq_pop);
            dones += int'(flush_done);
            step();
        end
        flush = 1'b0;
        chk("t5_pops", pops, 3);
        chk("t5_flush_done", dones, 1);
        #2;
        chk("t5_busy_idle", busy, 0);
        step();
        req_valid = 4'b0100;
        #2;
        chk("t5_resume", req_ready, 4'b0100);
        step();
        req_valid = '0;

        // T6: reset in the middle of DRAIN
        do_reset();
        for (int i = 0; i < 4; i++) push_one(3, EW'(8'h60 + i), "t6_fill");
        flush = 1'b1;
        #2;
        step();
        flush = 1'b0;
        #2;
        chk("t6_in_drain", pq_pop, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_pq_empty", pq_empty, 1);
        chk("t6_busy", busy, 0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            #2;
            dones += int'(flush_done);
            step();
        end
        chk("t6_no_done", dones, 0);
        req_valid = 4'b1000;
        #2;
        chk("t6_run", req_ready, 4'b1000);
        step();
        req_valid = '0;

        // Random run against a spec-level model of arbitration and the output register
        do_reset();
        m_last = NREQ - 1; m_ov = 1'b0; m_okv = '0; pend = '0;
        for (int i = 0; i < NREQ; i++) pkv[i] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pkv[i]  = EW'($urandom_range(0, 255));
                end
                req_kv[i*EW +: EW] = pkv[i];
            end
            req_valid = pend;
            out_ready = ((cyc / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #2;
            g = -1;
            if (q.size() < DEPTH) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && pend[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
                end
            end
            chk("rnd_req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
            if (g >= 0) chk("rnd_pq_kvi", pq_kvi, pkv[g]);
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov) chk("rnd_out_kv", out_kv, m_okv);
            ep = (q.size() > 0) && (!m_ov || out_ready);
            chk("rnd_pq_pop", pq_pop, ep);
            if (ep) begin
                m_ov = 1'b1;
                m_okv = q[0];
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (g >= 0) begin
                m_last = g;
                pend[g] = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
